// File: rtl/int_exc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : int_exc_arb
//  Purpose  : Interrupt / exception arbiter with a CP0-style register subset
//             (SR, CAUSE, EPC). It decides when the M-stage instruction is
//             redirected to the handler, and handles eret and nested
//             exceptions. Outputs are flush, pc_sel and pipe_stall_n.
//  Options  : INT_EXC_STICKY_IP_EN makes the CAUSE.IP bits sticky. In that
//             mode they are cleared by writing 1 to them with mtc0.
//  Revision : 1.0 - initial release
// ============================================================================
module int_exc_arb #(
   parameter int          N_IRQ      = 6,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             m_valid,
   input  logic [31:0]      m_pc,
   input  logic             m_bd,
   input  logic             exc_req,
   input  logic [4:0]       exc_code,
   input  logic             eret_in,
   input  logic             cp0_we,
   input  logic [1:0]       cp0_sel,
   input  logic [31:0]      cp0_wdata,
   output logic [31:0]      sr_out,
   output logic [31:0]      cause_out,
   output logic [31:0]      epc_out,
   output logic             flush,
   output logic             pipe_stall_n,
   output logic [1:0]       pc_sel
);

   // Catch bad configurations at elaboration. The fetch unit owns the
   // handler address, so this block only needs it to be word aligned.
   if (N_IRQ < 1 || N_IRQ > 8) begin : g_bad_n_irq
      $error("int_exc_arb: N_IRQ=%0d outside 1..8", N_IRQ);
   end
   if (HANDLER_PC[1:0] != 2'b00) begin : g_bad_handler_pc
      $error("int_exc_arb: HANDLER_PC %h is not word aligned", HANDLER_PC);
   end

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_TAKE    = 2'd1,
      ST_HANDLER = 2'd2,
      ST_RETURN  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [N_IRQ-1:0]   im_q, im_d;
   logic [N_IRQ-1:0]   ip_q, ip_d;
   logic               exl_q, exl_d;
   logic               ie_q, ie_d;
   logic               bd_q, bd_d;
   logic [4:0]         code_q, code_d;
   logic [31:0]        epc_q, epc_d;

   logic               sr_we;
   logic               epc_we;
   logic               int_pend;
   logic               take_evt;
   logic               nested_exc;

   assign sr_we      = cp0_we && (cp0_sel == 2'd0);
   assign epc_we     = cp0_we && (cp0_sel == 2'd2);
   assign int_pend   = (|(ip_q & im_q)) & ie_q & ~exl_q;
   // Only a real instruction can carry an exception or interrupt into EPC.
   assign take_evt   = (state_q == ST_RUN) && m_valid && (exc_req || int_pend);
   assign nested_exc = (state_q == ST_HANDLER) && m_valid && exc_req;

`ifdef INT_EXC_STICKY_IP_EN
   logic               cause_we;
   assign cause_we = cp0_we && (cp0_sel == 2'd1);
`endif

   // Next-state logic: the redirect states last one cycle each; exc_req beats eret in HANDLER.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:     if (take_evt) state_d = ST_TAKE;
         ST_TAKE:    state_d = ST_HANDLER;
         ST_HANDLER: if (eret_in && !exc_req) state_d = ST_RETURN;
         ST_RETURN:  state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   // Redirect outputs; forced to their idle values while reset is asserted.
   always_comb begin
      flush        = 1'b0;
      pc_sel       = 2'b00;
      pipe_stall_n = 1'b1;
      if (reset_n) begin
         case (state_q)
            ST_TAKE: begin
               flush        = 1'b1;
               pc_sel       = 2'b01;
               pipe_stall_n = 1'b0;
            end
            ST_RETURN: begin
               flush        = 1'b1;
               pc_sel       = 2'b10;
               pipe_stall_n = 1'b0;
            end
            ST_HANDLER: begin
               if (nested_exc) begin
                  flush  = 1'b1;
                  pc_sel = 2'b01;
               end
            end
            default: begin
               // An eret seen outside a handler still returns to EPC.
               if (eret_in && !take_evt) begin
                  flush  = 1'b1;
                  pc_sel = 2'b10;
               end
            end
         endcase
      end
   end

   // Register updates: mtc0 first, then hardware events override the same fields.
   always_comb begin
      im_d   = im_q;
      ie_d   = ie_q;
      exl_d  = exl_q;
      bd_d   = bd_q;
      code_d = code_q;
      epc_d  = epc_q;
`ifdef INT_EXC_STICKY_IP_EN
      ip_d   = irq_in | (ip_q & ~(cause_we ? cp0_wdata[10 +: N_IRQ] : {N_IRQ{1'b0}}));
`else
      ip_d   = irq_in;
`endif
      if (sr_we) begin
         im_d  = cp0_wdata[10 +: N_IRQ];
         exl_d = cp0_wdata[1];
         ie_d  = cp0_wdata[0];
      end
      if (epc_we) begin
         epc_d = cp0_wdata;
      end
      if (take_evt) begin
         exl_d  = 1'b1;
         bd_d   = m_bd;
         // A delay-slot instruction restarts at its branch (mod 2^32).
         epc_d  = m_bd ? (m_pc - 32'd4) : m_pc;
         code_d = exc_req ? exc_code : 5'd0;
      end
      if (nested_exc) begin
         code_d = exc_code;
      end
      if (state_q == ST_RETURN) begin
         exl_d = 1'b0;
         bd_d  = 1'b0;
      end
   end

   // State and CP0 registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         im_q    <= '0;
         ip_q    <= '0;
         exl_q   <= 1'b0;
         ie_q    <= 1'b0;
         bd_q    <= 1'b0;
         code_q  <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         im_q    <= im_d;
         ip_q    <= ip_d;
         exl_q   <= exl_d;
         ie_q    <= ie_d;
         bd_q    <= bd_d;
         code_q  <= code_d;
         epc_q   <= epc_d;
      end
   end

   // Assemble the architectural register views; unused bits read as zero.
   always_comb begin
      sr_out                 = '0;
      sr_out[10 +: N_IRQ]    = im_q;
      sr_out[1]              = exl_q;
      sr_out[0]              = ie_q;
      cause_out              = '0;
      cause_out[31]          = bd_q;
      cause_out[10 +: N_IRQ] = ip_q;
      cause_out[6:2]         = code_q;
      epc_out                = epc_q;
   end

endmodule
`default_nettype wire

// File: doc/int_exc_arb.md
INT_EXC_ARB -- requirements
Module: int_exc_arb

Interface
REQ-001 SHALL have parameter N_IRQ, default 6, number of external interrupt lines (1..8).
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, exception handler entry address.
REQ-003 SHALL have port clk input 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port irq_in input N_IRQ, level-sensitive external interrupt requests.
REQ-006 SHALL have port m_valid input 1, M stage holds a real (non-bubble) instruction.
REQ-007 SHALL have port m_pc input 32, PC of the M-stage instruction.
REQ-008 SHALL have port m_bd input 1, M-stage instruction is in a delay slot.
REQ-009 SHALL have port exc_req input 1, synchronous exception raised by the M-stage instruction.
REQ-010 SHALL have port exc_code input 5, ExcCode for exc_req.
REQ-011 SHALL have port eret_in input 1, eret in M stage.
REQ-012 SHALL have port cp0_we input 1, cp0_sel input 2 (0=SR, 1=CAUSE, 2=EPC), cp0_wdata input 32, the mtc0 write port.
REQ-013 SHALL have port sr_out, cause_out and epc_out output 32 each, the live register values.
REQ-014 SHALL have port flush output 1, pipe_stall_n output 1, and pc_sel output 2 (00 sequential, 01 HANDLER_PC, 10 epc_out).

Function
REQ-015 SHALL hold SR fields IM[N_IRQ-1:0] at SR[10+:N_IRQ], EXL at SR[1] and IE at SR[0]; all other SR bits read 0.
REQ-016 SHALL register irq_in into IP[N_IRQ-1:0] (CAUSE[10+:N_IRQ]) each cycle, one cycle of latency.
REQ-017 SHALL form int_pend = |(IP & IM) & IE & ~EXL.
REQ-018 SHALL implement FSM RUN, TAKE, HANDLER, RETURN.
REQ-019 In RUN with m_valid=1 and (exc_req or int_pend), the FSM SHALL go to TAKE; exc_req SHALL take priority over the interrupt.
REQ-020 On entry to TAKE, the block SHALL set EXL=1, set CAUSE.BD=m_bd, and set EPC = m_bd ? m_pc-4 : m_pc; it SHALL set CAUSE[6:2]=exc_code on an exception and 0 on an interrupt.
REQ-021 In TAKE (exactly one cycle), the block SHALL assert flush=1 and pc_sel=01, then go to HANDLER.
REQ-022 In HANDLER, an exc_req with m_valid SHALL assert flush and pc_sel=01 for one cycle and update CAUSE.ExcCode, but SHALL NOT update EPC or BD (nested exception).
REQ-023 In HANDLER with eret_in=1 and exc_req=0, the FSM SHALL go to RETURN; if both are set in the same cycle, the block SHALL treat the event as an exception per REQ-022.
REQ-024 In RETURN (one cycle), the block SHALL assert flush=1, pc_sel=10 and clear EXL and BD, then go to RUN.
REQ-025 eret_in in RUN SHALL still redirect to epc_out for one cycle but SHALL leave the state in RUN.
REQ-026 pipe_stall_n SHALL be 0 only in TAKE and RETURN.
REQ-027 An mtc0 write SHALL take effect on the next edge; a TAKE or RETURN update of the same field SHALL win over an mtc0 write in the same cycle.
REQ-028 EPC arithmetic SHALL be 32-bit modulo: m_pc=0 with m_bd=1 SHALL give EPC=32'hFFFF_FFFC.
REQ-029 Interrupts SHALL NOT be taken when m_valid=0; they SHALL stay pending until a valid instruction reaches M.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=RUN, SR=0, CAUSE=0, EPC=0, flush=0, pc_sel=00, pipe_stall_n=1.
REQ-031 A reset asserted during TAKE or RETURN SHALL abort the redirect with no residual flush after release.

Configuration
REQ-032 With macro INT_EXC_STICKY_IP_EN defined, IP bits SHALL be set by irq_in and cleared only by an mtc0 write to CAUSE, which SHALL clear every IP bit written as 1 (write-one-to-clear).
REQ-033 Without INT_EXC_STICKY_IP_EN, IP SHALL follow REQ-016, and CAUSE IP bits SHALL NOT be writable.

Verification
REQ-034 Reset, then SR=0x0000_0401 and irq_in[0]=1 with m_valid=1 and m_pc=0x3000 -> flush one cycle, pc_sel=01, EPC=0x3000, ExcCode=0, EXL=1.
REQ-035 exc_req=1, exc_code=12, m_bd=1, m_pc=0x3010 in the same cycle as an enabled IRQ -> ExcCode=12, BD=1, EPC=0x300C.
REQ-036 In HANDLER, exc_req=1 and eret_in=1 together -> pc_sel=01, EPC unchanged, EXL remains 1; a later eret_in alone -> pc_sel=10, EXL=0, state RUN.
REQ-037 Enabled IRQ with m_valid=0 for 5 cycles, then m_valid=1 -> TAKE occurs only on the first valid cycle.
REQ-038 With INT_EXC_STICKY_IP_EN defined, pulse irq_in[2] for one cycle -> IP[2] stays 1 until an mtc0 write of 0x0000_1000 to CAUSE; reset_n low mid-TAKE -> all outputs at reset values.
